uart_tx_arbiter: RTL

Shares one uart_tx transmitter among NUM_REQ byte requesters using round-robin arbitration. Each requester uses a valid/ready handshake. The block holds the granted byte and drives the transmitter's tx_start/data_in. It waits for the frame-complete tick, then optionally inserts an inter-frame gap. It sits between the SEC-DED encoder/FIFO clients and the uart_tx datapath, on the same clk/s_tick domain.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding and sizing defaults.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    localparam int OVERSAMPLE        = 16;
    localparam int DEFAULT_DATA_SIZE = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts just above last_grant and wraps.
// Rotate so last_grant+1 lands at bit 0, take the lowest set bit, then map back to a requester index.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any_req
);
    localparam int IW = $clog2(N);

    logic [N-1:0] rot;
    int           pos;
    int           sel;

    assign any_req = |req;

    always_comb begin
        rot = N'({req, req} >> (int'(last_grant) + 1));
        pos = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) pos = i;
        end
        sel       = (pos + int'(last_grant) + 1) % N;
        grant_idx = IW'(sel);
        grant     = any_req ? (N'(1) << sel) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uart_tx among NUM_REQ valid/ready byte sources; accepts one byte per frame
// and holds it until the qualified done (plus GAP_TICKS s_ticks). UART_TX_TIMEOUT_EN adds a frame timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_SIZE     = DEFAULT_DATA_SIZE,
    parameter int GAP_TICKS     = 0,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         s_tick,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         utx_start,
    output logic [DATA_SIZE-1:0]         utx_data,
    input  logic                         utx_done_tick,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    input  logic                         err_clr,
    output logic                         err_timeout
);
    localparam int IW = $clog2(NUM_REQ);

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] hold_q;
    logic [IW-1:0]        grant_q, last_q;
    logic [15:0]          gap_q, gap_d;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [IW-1:0]        arb_idx;
    logic                 arb_any;
    logic                 accept;
    logic                 frame_done;
    logic                 timeout_hit;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any_req    (arb_any)
    );

    assign accept     = (state_q == IDLE) && arb_any;
    // done from the transmitter only counts when it coincides with the oversampling tick
    assign frame_done = utx_done_tick && s_tick;

`ifdef UART_TX_TIMEOUT_EN
    logic [15:0] to_q;
    logic        err_q;
    logic        in_frame;

    assign in_frame    = (state_q == LAUNCH) || (state_q == WAIT_DONE);
    assign timeout_hit = in_frame && s_tick && (to_q == 16'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept)
                to_q <= '0;
            else if (in_frame && s_tick)
                to_q <= to_q + 16'd1;
            if (timeout_hit)
                err_q <= 1'b1;
            else if (err_clr)
                err_q <= 1'b0;
        end
    end

    assign err_timeout = err_q;
`else
    logic        unused_err_clr;
    logic [15:0] unused_timeout_ticks;

    assign unused_err_clr       = err_clr;
    assign unused_timeout_ticks = 16'(TIMEOUT_TICKS);
    assign timeout_hit          = 1'b0;
    assign err_timeout          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (arb_any) state_d = LAUNCH;
            end
            LAUNCH: begin
                if (timeout_hit)  state_d = IDLE;
                else if (s_tick)  state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (frame_done)       state_d = (GAP_TICKS > 0) ? GAP : IDLE;
                else if (timeout_hit) state_d = IDLE;
            end
            GAP: begin
                if (s_tick) begin
                    if (gap_q == 16'(GAP_TICKS - 1)) begin
                        state_d = IDLE;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gap_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            if (accept) begin
                hold_q  <= req_data[arb_idx*DATA_SIZE +: DATA_SIZE];
                grant_q <= arb_idx;
                last_q  <= arb_idx;
            end
        end
    end

    assign req_ready = accept ? arb_grant : '0;
    assign utx_start = (state_q == LAUNCH);
    assign utx_data  = hold_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != IDLE);

endmodule
